// File: rtl/sys_ctrl_tx.sv
// Transmit-side system controller: buffers one RF byte and one ALU result,
// then serializes them (ALU first, LSB then MSB) over a valid/ready byte link.
module sys_ctrl_tx #(
   parameter int data_Width = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    UART_RF_SEND,
   input  logic [data_Width-1:0]   UART_SEND_RF_DATA,
   input  logic                    UART_ALU_SEND,
   input  logic [2*data_Width-1:0] UART_SEND_ALU_DATA,
   input  logic                    TX_READY,
   output logic [data_Width-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   output logic                    CTRL_TX_BUSY,
   output logic                    TX_OVERRUN
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RF_BYTE = 2'd1,
      ALU_LSB = 2'd2,
      ALU_MSB = 2'd3
   } state_t;

   state_t                    state, state_nxt;
   logic                      rf_pend, alu_pend;
   logic [data_Width-1:0]     rf_buf;
   logic [2*data_Width-1:0]   alu_buf;
   logic [data_Width-1:0]     msb_hold;
   logic [data_Width-1:0]     data_nxt;
   logic                      vld_nxt;
   logic                      xfer, alu_take, rf_take;

   assign xfer     = TX_D_VLD & TX_READY;
   assign alu_take = (state == IDLE) & alu_pend;
   assign rf_take  = (state == IDLE) & ~alu_pend & rf_pend;

   assign CTRL_TX_BUSY = (state != IDLE) | rf_pend | alu_pend;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      data_nxt  = TX_P_DATA;
      vld_nxt   = TX_D_VLD;
      case (state)
         IDLE: begin
            if (alu_pend) begin
               data_nxt  = alu_buf[data_Width-1:0];
               vld_nxt   = 1'b1;
               state_nxt = ALU_LSB;
            end else if (rf_pend) begin
               data_nxt  = rf_buf;
               vld_nxt   = 1'b1;
               state_nxt = RF_BYTE;
            end else begin
               vld_nxt   = 1'b0;
            end
         end
         RF_BYTE: if (xfer) begin
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
         end
         ALU_LSB: if (xfer) begin
            // MSB comes from the hold copy so a fresh ALU strobe cannot corrupt it.
            data_nxt  = msb_hold;
            vld_nxt   = 1'b1;
            state_nxt = ALU_MSB;
         end
         ALU_MSB: if (xfer) begin
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
         end
         default: begin
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
         msb_hold  <= '0;
      end else begin
         state     <= state_nxt;
         TX_P_DATA <= data_nxt;
         TX_D_VLD  <= vld_nxt;
         if (alu_take)
            msb_hold <= alu_buf[2*data_Width-1:data_Width];
      end
   end

   // A strobe in the consuming cycle wins over the clear: old value leaves, new one stays pending.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rf_pend    <= 1'b0;
         rf_buf     <= '0;
         alu_pend   <= 1'b0;
         alu_buf    <= '0;
         TX_OVERRUN <= 1'b0;
      end else begin
         TX_OVERRUN <= (UART_RF_SEND  & rf_pend  & ~rf_take) |
                       (UART_ALU_SEND & alu_pend & ~alu_take);
         if (UART_RF_SEND) begin
            rf_pend <= 1'b1;
            rf_buf  <= UART_SEND_RF_DATA;
         end else if (rf_take) begin
            rf_pend <= 1'b0;
         end
         if (UART_ALU_SEND) begin
            alu_pend <= 1'b1;
            alu_buf  <= UART_SEND_ALU_DATA;
         end else if (alu_take) begin
            alu_pend <= 1'b0;
         end
      end
   end

endmodule

// File: doc/sys_ctrl_tx.md
Name: sys_ctrl_tx

Overview:
- Transmit-side controller of the system control path. It is the counterpart of the receive-side command controller.
- Accepts RF read-back bytes and 16-bit ALU results, each with a one-cycle send strobe from the receive-side controller.
- Buffers one pending item of each kind and serializes them into bytes over a valid/ready handshake to the UART transmitter.
- ALU results go out as two bytes, LSB first.

Parameters:
data_Width, 8, width of one UART byte; ALU result width is 2*data_Width

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
UART_RF_SEND  input  1  one-cycle strobe: RF read data available
UART_SEND_RF_DATA  input  data_Width  RF byte; sampled on strobe cycle
UART_ALU_SEND  input  1  one-cycle strobe: ALU result available
UART_SEND_ALU_DATA  input  2*data_Width  ALU result; sampled on strobe cycle
TX_READY  input  1  UART transmitter can accept a byte this cycle
TX_P_DATA  output  data_Width  byte to transmit (registered)
TX_D_VLD  output  1  TX_P_DATA valid (registered)
CTRL_TX_BUSY  output  1  any item pending or in flight
TX_OVERRUN  output  1  one-cycle pulse: a pending item was overwritten before it was sent

Behaviour:
- One clock domain. Reset is asynchronous and active-low (RST); everything else is synchronous to CLK.
- Reset values: TX_P_DATA=0, TX_D_VLD=0, TX_OVERRUN=0, both pending flags=0, both pending data registers=0, state=IDLE.
- CTRL_TX_BUSY is combinational: (state!=IDLE) | rf_pend | alu_pend. It is 0 after reset.
- Byte transfer happens on a rising edge where TX_D_VLD=1 and TX_READY=1.
- While TX_D_VLD=1 and TX_READY=0, TX_P_DATA and TX_D_VLD hold unchanged.
- Pending buffers, one entry each:
  - UART_RF_SEND=1 at an edge: rf_pend<=1, rf_buf<=UART_SEND_RF_DATA.
  - UART_ALU_SEND=1 at an edge: alu_pend<=1, alu_buf<=UART_SEND_ALU_DATA.
  - Strobe while the matching flag is already 1 and that flag is not being consumed in the same cycle: the buffer is overwritten and TX_OVERRUN pulses 1 on the next cycle.
  - Strobe in the same cycle the FSM consumes that buffer: the consumed value is the old one, the new one is stored, the flag stays 1, and there is no overrun.
- FSM states: IDLE, RF_BYTE, ALU_LSB, ALU_MSB.
  - IDLE, alu_pend=1: TX_P_DATA<=alu_buf[data_Width-1:0], TX_D_VLD<=1, capture alu_buf MSB into a hold register, alu_pend<=0, go to ALU_LSB. ALU has priority.
  - IDLE, alu_pend=0 and rf_pend=1: TX_P_DATA<=rf_buf, TX_D_VLD<=1, rf_pend<=0, go to RF_BYTE.
  - IDLE, nothing pending: TX_D_VLD=0, stay.
  - RF_BYTE, on transfer: TX_D_VLD<=0, go to IDLE.
  - ALU_LSB, on transfer: TX_P_DATA<=held MSB, TX_D_VLD<=1, go to ALU_MSB. The LSB and MSB bytes are back-to-back, with no idle cycle between them.
  - ALU_MSB, on transfer: TX_D_VLD<=0, go to IDLE.
  - No transfer: stay in the current state.
  - Illegal state: go to IDLE with TX_D_VLD=0.
- Latency: strobe sampled at edge n, item pending from n. If the FSM is in IDLE after edge n, TX_D_VLD rises at edge n+1.
- Gap between items: at least one cycle with TX_D_VLD=0, because the FSM passes through IDLE.
- A new ALU or RF strobe never disturbs a byte already presented on TX_P_DATA. The ALU MSB is taken from the hold register, not from alu_buf.
- Reset mid-frame: all pending data is discarded, TX_D_VLD drops to 0 immediately, and no partial ALU frame resumes after reset.

Test Plan:
- RF single: RF strobe with 0x5A, TX_READY=1 → TX_D_VLD=1 one cycle after the strobe edge, TX_P_DATA=0x5A for one cycle; TX_D_VLD=0 the following cycle; CTRL_TX_BUSY returns to 0.
- ALU two-byte: ALU strobe with 0xBEEF, TX_READY=1 → bytes 0xEF then 0xBE on consecutive cycles; then TX_D_VLD=0.
- Backpressure: TX_READY=0 for 5 cycles during an ALU frame 0x1234 → TX_P_DATA holds 0x34 with TX_D_VLD=1; after TX_READY rises, 0x34 then 0x12 are sent, each exactly once.
- Simultaneous: RF strobe 0x11 and ALU strobe 0xAAB0 in the same cycle → bytes in order 0xB0, 0xAA, 0x11; no TX_OVERRUN.
- Overrun: TX_READY=0, two RF strobes (0x01 then 0x02) while the first RF byte is held and a third RF strobe 0x03 follows → TX_OVERRUN pulses once; bytes sent are 0x01 then 0x03.
- Reset mid-frame: assert RST while ALU_MSB is pending → TX_D_VLD=0 asynchronously and all outputs at reset values; after release with no strobes, no byte is ever sent.
